// File: rtl/mem_array_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_array_if
// Description : Write/read/clear bus for the mem_array scratch store.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_array_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
);
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             clr;
  logic             busy;

  modport master (
    output wr_en, wr_addr, din, rd_en, rd_addr, clr,
    input  dout, dout_valid, busy
  );

  modport slave (
    input  wr_en, wr_addr, din, rd_en, rd_addr, clr,
    output dout, dout_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_array
// Description : DEPTH x WIDTH register memory, registered read with write-first
//               bypass, and a one-word-per-cycle hardware clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  wire logic   clk,
  input  wire logic   reset,
  mem_array_if.slave  bus
);

  localparam logic [AW:0]   c_depth = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] c_last  = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_ptr;
  logic [AW-1:0]    w_ptr_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;

  logic             w_clearing;
  logic             w_wr_ok;
  logic             w_rd_inrange;
  logic [WIDTH-1:0] w_rd_word;
  logic [WIDTH-1:0] w_rd_data;

  assign w_clearing   = (r_state == S_CLEAR);
  assign w_wr_ok      = bus.wr_en && !w_clearing && ({1'b0, bus.wr_addr} < c_depth);
  assign w_rd_inrange = ({1'b0, bus.rd_addr} < c_depth);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // The pointer parks at 0 when the sweep ends so it never runs past DEPTH-1.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (bus.clr) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      S_CLEAR: begin
        if (r_ptr == c_last) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt   = r_ptr + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.rd_addr == AW'(i)) begin
        w_rd_word = r_mem[i];
      end
    end
  end

  // Words at or below the pointer read as zero: already swept or swept this edge.
  always_comb begin
    w_rd_data = '0;
    if (!w_rd_inrange) begin
      w_rd_data = '0;
    end else if (w_clearing && (bus.rd_addr <= r_ptr)) begin
      w_rd_data = '0;
    end else if (w_wr_ok && (bus.wr_addr == bus.rd_addr)) begin
      w_rd_data = bus.din;
    end else begin
      w_rd_data = w_rd_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_clearing && (r_ptr == AW'(i))) begin
          r_mem[i] <= '0;
        end else if (w_wr_ok && (bus.wr_addr == AW'(i))) begin
          r_mem[i] <= bus.din;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= bus.rd_en;
      if (bus.rd_en) begin
        r_dout <= w_rd_data;
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.busy       = w_clearing;

endmodule
`default_nettype wire

// File: doc/mem_array.md
Name: mem_array

Overview:
- Parametrised multi-word register memory: DEPTH words of WIDTH bits; replaces the single fixed 8-bit storage register.
- Synchronous write port and one-cycle registered read port.
- Read-during-write bypass.
- Hardware clear sequencer that zeroes the whole array, one word per cycle, without a reset.
- Sits between datapath producers and consumers as a small scratch store.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of words (>=2).
- AW, 4, address width; must satisfy 2^AW >= DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- wr_en  input  1  write strobe, sampled on the clk edge.
- wr_addr  input  AW  write address.
- din  input  WIDTH  write data.
- rd_en  input  1  read strobe, sampled on the clk edge.
- rd_addr  input  AW  read address.
- dout  output  WIDTH  registered read data.
- dout_valid  output  1  high for exactly the cycle after a sampled rd_en.
- clr  input  1  clear request, sampled on the clk edge.
- busy  output  1  high while the clear sweep is running.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - all words = 0; dout = 0; dout_valid = 0; busy = 0.
  - FSM = IDLE; sweep pointer = 0.
  - Reset asserted mid-sweep aborts the sweep; the array is zero anyway.
- Write:
  - Accepted on a rising edge when wr_en=1, busy=0 and wr_addr<DEPTH: mem[wr_addr] <= din.
  - wr_addr>=DEPTH: write dropped, no alias.
  - wr_en while busy=1: ignored.
- Read, latency 1:
  - On an edge with rd_en=1: dout <= mem[rd_addr] and dout_valid <= 1.
  - rd_en=0: dout holds its last value and dout_valid <= 0.
  - rd_addr>=DEPTH: dout <= 0, dout_valid <= 1.
- Read and write to the same address on the same edge: write-first, so dout <= din.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on an edge with clr=1; the pointer loads 0.
  - In CLEAR, each edge: mem[ptr] <= 0, ptr <= ptr+1.
  - The edge that clears word DEPTH-1 returns the FSM to IDLE.
  - The sweep occupies exactly DEPTH cycles.
  - busy is registered: it is 1 in every cycle the FSM is in CLEAR, rising the cycle after clr is sampled and falling the cycle after the last word is cleared.
  - clr while busy: ignored; the sweep does not restart.
  - clr together with wr_en in IDLE: the write is performed on that edge, and the sweep then zeroes that word.
  - Reads during CLEAR are honoured:
    - already-cleared words (index < ptr) return 0;
    - a read of the word being cleared on that edge returns 0 (clear-first);
    - not-yet-cleared words return their old content.
- Widths:
  - Addresses are unsigned.
  - The pointer is AW bits wide and never wraps past DEPTH-1.
  - No arithmetic on data.

Test Plan:
1. Reset values: hold reset=0 for 3 cycles, then release -> dout=0x00, dout_valid=0, busy=0; reading addresses 0..15 returns 0x00 each, with dout_valid=1 one cycle after each rd_en.
2. Write then read: write 0xA5 to addr 3 and 0x3C to addr 15; read addr 3 then addr 15 on consecutive cycles -> dout=0xA5, then 0x3C, one cycle later each. Write 0xFF to addr 16 (AW=5 build, DEPTH=16) -> a subsequent read of addr 0 is unchanged.
3. Bypass: addr 7 holds 0x11; on a single edge write 0x22 to addr 7 and read addr 7 -> the next cycle dout=0x22. A read on the following edge also returns 0x22.
4. Clear sweep:
   - Fill addrs 0..15 with 0x80+addr; pulse clr for 1 cycle -> busy=1 for exactly 16 cycles.
   - wr_en of 0x55 to addr 2 mid-sweep is ignored.
   - Reading addr 15 at sweep cycle 5 returns 0x8F; reading addr 4 at sweep cycle 5 returns 0x00.
   - After busy falls, all words read 0x00.
   - A second clr pulse mid-sweep does not extend busy beyond 16 cycles.
5. Reset mid-sweep: start a clear, then assert reset=0 asynchronously between clock edges at sweep cycle 6 -> busy, dout and dout_valid drop to 0 immediately; after release, writes are accepted on the first edge and all untouched words read 0x00.
6. Hold: read addr 3 (0xA5), then hold rd_en=0 for 4 cycles -> dout remains 0xA5 and dout_valid=0 for those 4 cycles.
